// File: rtl/dlfloat_operand_seq.sv
// Pairs an alternating A/B DLFloat16 word stream into operand pairs, tags vector
// boundaries (first/last) and buffers them in a first-word-fall-through FIFO for a MAC.
module dlfloat_operand_seq #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic [15:0]              data_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               vec_len,
  output logic [15:0]              op_a,
  output logic [15:0]              op_b,
  output logic                     op_valid,
  input  logic                     op_ready,
  output logic                     op_first,
  output logic                     op_last,
  output logic                     op_zero,
  output logic [$clog2(DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {WAIT_A, WAIT_B} state_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        first;
    logic        last;
  } pair_t;

  state_t        state_q, state_d;
  logic [15:0]   temp_q, temp_d;
  logic [3:0]    idx_q, idx_d;
  logic [4:0]    len_q, len_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  pair_t         mem_q [DEPTH];

  logic  full, accept, push, pop, is_last;
  pair_t head, wr_pair;

  always_comb begin
    state_d  = state_q;
    temp_d   = temp_q;
    idx_d    = idx_q;
    len_d    = len_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    full     = (level_q == LW'(DEPTH));
    // Only a B word needs a free slot; an A word just lands in the temp register.
    in_ready = !rst_n || (!clr && !((state_q == WAIT_B) && full));
    accept   = in_valid && in_ready;
    push     = accept && (state_q == WAIT_B);
    op_valid = rst_n && (level_q != '0);
    pop      = op_valid && op_ready;
    head     = mem_q[rd_ptr_q];

    is_last  = ({1'b0, idx_q} == (len_q - 5'd1));
    wr_pair  = '{a: temp_q, b: data_in, first: (idx_q == 4'd0), last: is_last};

    case (state_q)
      WAIT_A: if (accept) begin
        temp_d  = data_in;
        state_d = WAIT_B;
        if (idx_q == 4'd0) len_d = (vec_len == 4'd0) ? 5'd16 : {1'b0, vec_len};
      end
      WAIT_B: if (accept) begin
        state_d  = WAIT_A;
        wr_ptr_d = wr_ptr_q + AW'(1);
        idx_d    = is_last ? 4'd0 : idx_q + 4'd1;
      end
      default: state_d = WAIT_A;
    endcase

    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (clr) begin
      state_d  = WAIT_A;
      temp_d   = '0;
      idx_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end

    op_a       = op_valid ? head.a : '0;
    op_b       = op_valid ? head.b : '0;
    op_first   = op_valid && head.first;
    op_last    = op_valid && head.last;
    op_zero    = op_valid && ((head.a[14:0] == '0) || (head.b[14:0] == '0));
    fifo_level = level_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= WAIT_A;
      temp_q   <= '0;
      idx_q    <= '0;
      len_q    <= 5'd16;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      state_q  <= state_d;
      temp_q   <= temp_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: level/pointers gate everything read out of it.
  always_ff @(posedge clk) begin
    if (rst_n && push) mem_q[wr_ptr_q] <= wr_pair;
  end

endmodule

// File: tb/tb_dlfloat_operand_seq.sv
// Bench for dlfloat_operand_seq: directed scenarios plus a randomized run checked
// against a queue-based reference model.
module tb_dlfloat_operand_seq;
  localparam int DEPTH = 4;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        clr = 0;
  logic [15:0] data_in = '0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [3:0]  vec_len = '0;
  logic [15:0] op_a, op_b;
  logic        op_valid, op_ready = 0, op_first, op_last, op_zero;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;

  dlfloat_operand_seq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .vec_len(vec_len), .op_a(op_a), .op_b(op_b),
    .op_valid(op_valid), .op_ready(op_ready), .op_first(op_first), .op_last(op_last),
    .op_zero(op_zero), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of tagged pairs plus the pending-A / vector-position bookkeeping.
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          f;
    bit          l;
  } pair_t;

  pair_t       mq[$];
  bit          m_have_a = 0;
  logic [15:0] m_a = '0;
  int          m_pos = 0;
  int          m_len = 16;
  bit          m_acc, m_pop;
  pair_t       m_new;

  function automatic bit is_zero(logic [15:0] w);
    return (w[14:9] == 6'd0) && (w[8:0] == 9'd0);
  endfunction

  function automatic bit exp_in_ready();
    return !rst_n || (!clr && !(m_have_a && mq.size() == DEPTH));
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete(); m_have_a = 0; m_pos = 0; m_len = 16;
    end else if (clr) begin
      mq.delete(); m_have_a = 0; m_pos = 0;
    end else begin
      m_acc = in_valid && exp_in_ready();
      m_pop = (mq.size() != 0) && op_ready;
      if (m_pop) void'(mq.pop_front());
      if (m_acc) begin
        if (!m_have_a) begin
          if (m_pos == 0) m_len = (vec_len == 0) ? 16 : int'(vec_len);
          m_a = data_in;
          m_have_a = 1;
        end else begin
          m_new.a = m_a; m_new.b = data_in;
          m_new.f = (m_pos == 0); m_new.l = (m_pos == m_len - 1);
          mq.push_back(m_new);
          m_pos = (m_pos + 1) % m_len;
          m_have_a = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_clr();
    clr = 1; in_valid = 0; step(); clr = 0;
  endtask

  task automatic send_word(input logic [15:0] d);
    int n = 0;
    in_valid = 1; data_in = d; #1;
    while (!in_ready && n < 50) begin step(); #1; n++; end
    checks++;
    if (n >= 50) begin
      errors++; $display("FAIL send_word timeout: in_ready=%0b required 1 (word %h)", in_ready, d);
    end
    step();
    in_valid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; step(); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %0b want 1", in_ready); end
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL reset op_valid: got %0b want 0", op_valid); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset level: got %0d want 0", fifo_level); end
    rst_n = 1; #1;
    checks++;
    if ({op_a, op_b, op_first, op_last, op_zero, op_valid, in_ready} !== {35'd0, 1'b1}) begin
      errors++; $display("FAIL post_reset outputs: a=%h b=%h f=%0b l=%0b z=%0b v=%0b rdy=%0b want zeros, rdy=1",
                         op_a, op_b, op_first, op_last, op_zero, op_valid, in_ready);
    end
  endtask

  task automatic test_basic();
    logic [15:0] w [6] = '{16'h3C00, 16'h3C00, 16'h3E00, 16'h4000, 16'h4000, 16'h4000};
    do_clr(); op_ready = 1; vec_len = 4'd3;
    for (int k = 0; k < 3; k++) begin
      send_word(w[2*k]); send_word(w[2*k+1]); #1;
      checks++;
      if (op_valid !== 1'b1 || op_a !== w[2*k] || op_b !== w[2*k+1]) begin
        errors++; $display("FAIL basic pair%0d: v=%0b a=%h b=%h want v=1 a=%h b=%h", k, op_valid, op_a, op_b, w[2*k], w[2*k+1]);
      end
      checks++;
      if (op_first !== (k == 0) || op_last !== (k == 2)) begin
        errors++; $display("FAIL basic tags%0d: first=%0b last=%0b want %0b %0b", k, op_first, op_last, k == 0, k == 2);
      end
    end
    step(); op_ready = 0;
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    logic [2:0]  lv [10];
    bit          take;
    do_clr(); op_ready = 0; vec_len = 4'd4;
    for (int i = 0; i < 9; i++) send_word(16'h1000 + 16'(i));
    #1;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL bp level: got %0d want 4", fifo_level); end
    in_valid = 1; data_in = 16'h1009; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp stall_b: in_ready=%0b want 0", in_ready); end
    op_ready = 1;
    for (int c = 0; c < 10; c++) begin
      if (op_valid) got.push_back({op_a, op_b});
      take = in_valid && in_ready;
      step();
      if (take) in_valid = 0;
      lv[c] = fifo_level;
    end
    checks++; if (lv[0] !== 3'd3) begin errors++; $display("FAIL bp pop_only level: got %0d want 3", lv[0]); end
    checks++; if (lv[1] !== 3'd3) begin errors++; $display("FAIL bp push_pop level: got %0d want 3", lv[1]); end
    checks++; if (got.size() != 5) begin errors++; $display("FAIL bp count: got %0d pairs want 5", got.size()); end
    for (int k = 0; k < 5 && k < got.size(); k++) begin
      checks++;
      if (got[k] !== {16'h1000 + 16'(2*k), 16'h1000 + 16'(2*k+1)}) begin
        errors++; $display("FAIL bp order%0d: got %h want %h%h", k, got[k], 16'h1000 + 16'(2*k), 16'h1000 + 16'(2*k+1));
      end
    end
    op_ready = 0;
  endtask

  task automatic test_veclen0();
    do_clr(); op_ready = 1; vec_len = 4'd0;
    for (int k = 0; k < 16; k++) begin
      if (k == 4) vec_len = 4'd2;
      send_word(16'h2000 + 16'(k)); send_word(16'h2100 + 16'(k)); #1;
      checks++;
      if (op_first !== (k == 0) || op_last !== (k == 15)) begin
        errors++; $display("FAIL len16 pair%0d: first=%0b last=%0b want %0b %0b", k, op_first, op_last, k == 0, k == 15);
      end
    end
    for (int k = 0; k < 2; k++) begin
      send_word(16'h2200); send_word(16'h2300); #1;
      checks++;
      if (op_first !== (k == 0) || op_last !== (k == 1)) begin
        errors++; $display("FAIL len2 pair%0d: first=%0b last=%0b want %0b %0b", k, op_first, op_last, k == 0, k == 1);
      end
    end
    step(); op_ready = 0;
  endtask

  task automatic test_clr();
    do_clr(); op_ready = 0; vec_len = 4'd3;
    send_word(16'h3C00); send_word(16'h3C00); send_word(16'h1111);
    clr = 1; in_valid = 1; data_in = 16'h5555; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clr in_ready: got %0b want 0", in_ready); end
    step(); clr = 0; in_valid = 0; #1;
    checks++;
    if (fifo_level !== 3'd0 || op_valid !== 1'b0) begin
      errors++; $display("FAIL clr flush: level=%0d valid=%0b want 0 0", fifo_level, op_valid);
    end
    send_word(16'h8000); send_word(16'h4000); #1;
    checks++;
    if (op_a !== 16'h8000 || op_b !== 16'h4000 || op_first !== 1'b1 || op_last !== 1'b0 || op_zero !== 1'b1) begin
      errors++; $display("FAIL clr next_pair: a=%h b=%h f=%0b l=%0b z=%0b want 8000 4000 1 0 1",
                         op_a, op_b, op_first, op_last, op_zero);
    end
  endtask

  task automatic test_reset_mid();
    do_clr(); op_ready = 0; vec_len = 4'd5;
    for (int i = 0; i < 6; i++) send_word(16'h4400 + 16'(i));
    #1;
    checks++; if (fifo_level !== 3'd3) begin errors++; $display("FAIL rstmid level: got %0d want 3", fifo_level); end
    rst_n = 0; step(); #1;
    checks++;
    if (op_valid !== 1'b0 || fifo_level !== 3'd0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid during: v=%0b lvl=%0d rdy=%0b want 0 0 1", op_valid, fifo_level, in_ready);
    end
    rst_n = 1; step(); #1;
    checks++;
    if (op_valid !== 1'b0 || fifo_level !== 3'd0 || in_ready !== 1'b1 || op_a !== 16'h0) begin
      errors++; $display("FAIL rstmid after: v=%0b lvl=%0d rdy=%0b a=%h want 0 0 1 0000", op_valid, fifo_level, in_ready, op_a);
    end
  endtask

  task automatic test_random();
    pair_t h;
    logic [15:0] ea, eb;
    bit ef, el, ez, ev;
    int rdy_bias;
    for (int c = 0; c < 3000; c++) begin
      rdy_bias = ((c / 300) % 2 == 0) ? 7 : 3;
      rst_n    = ($urandom_range(0, 199) != 0);
      clr      = ($urandom_range(0, 49) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      op_ready = ($urandom_range(0, 9) < rdy_bias);
      vec_len  = 4'($urandom_range(0, 4));
      case ($urandom_range(0, 5))
        0:       data_in = 16'h0000;
        1:       data_in = 16'h8000;
        default: data_in = 16'($urandom);
      endcase
      #1;
      ev = rst_n && (mq.size() != 0);
      if (ev) begin
        h = mq[0]; ea = h.a; eb = h.b; ef = h.f; el = h.l; ez = is_zero(h.a) || is_zero(h.b);
      end else begin
        ea = '0; eb = '0; ef = 0; el = 0; ez = 0;
      end
      checks++;
      if (in_ready !== exp_in_ready()) begin
        errors++; $display("FAIL rand in_ready c=%0d: got %0b want %0b", c, in_ready, exp_in_ready());
      end
      checks++;
      if (op_valid !== ev) begin
        errors++; $display("FAIL rand op_valid c=%0d: got %0b want %0b", c, op_valid, ev);
      end
      checks++;
      if (fifo_level !== 3'(mq.size())) begin
        errors++; $display("FAIL rand level c=%0d: got %0d want %0d", c, fifo_level, mq.size());
      end
      checks++;
      if ({op_a, op_b, op_first, op_last, op_zero} !== {ea, eb, ef, el, ez}) begin
        errors++; $display("FAIL rand head c=%0d: got a=%h b=%h f=%0b l=%0b z=%0b want a=%h b=%h f=%0b l=%0b z=%0b",
                           c, op_a, op_b, op_first, op_last, op_zero, ea, eb, ef, el, ez);
      end
      step();
    end
    rst_n = 1; clr = 0; in_valid = 0; op_ready = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_veclen0();
    test_clr();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
